// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS MEM stage
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] BUBBLE   = 32'd0;
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;
  localparam int          REG_W    = 5;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with load and bubble controls
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             bubble,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic [31:0]      read_data,
  input  logic [31:0]      alu_out,
  input  logic [REG_W-1:0] write_reg,
  output logic             reg_write_w,
  output logic             mem_to_reg_w,
  output logic [31:0]      read_data_w,
  output logic [31:0]      alu_out_w,
  output logic [REG_W-1:0] write_reg_w
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      read_data_w  <= BUBBLE;
      alu_out_w    <= BUBBLE;
      write_reg_w  <= '0;
    end else if (load) begin
      if (bubble) begin
        reg_write_w  <= 1'b0;
        mem_to_reg_w <= 1'b0;
        read_data_w  <= BUBBLE;
        alu_out_w    <= BUBBLE;
        write_reg_w  <= '0;
      end else begin
        reg_write_w  <= reg_write;
        mem_to_reg_w <= mem_to_reg;
        read_data_w  <= read_data;
        alu_out_w    <= alu_out;
        write_reg_w  <= write_reg;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: branch resolve, req/ack data-memory FSM, MEM/WB outputs
// Optional bus timeout with sticky mem_err port: define MEM_TIMEOUT_EN.
module mem_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic              BranchM,
  input  logic              ZeroM,
  input  logic [31:0]       ALUOutM,
  input  logic [31:0]       WriteDataM,
  input  logic [REG_W-1:0]  WriteRegM,
  input  logic [31:0]       PCBranchM,
  output logic              PCSrcM,
  output logic [31:0]       PCBranchF,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [31:0]       ReadDataW,
  output logic [31:0]       ALUOutW,
  output logic [REG_W-1:0]  WriteRegW
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              mem_err
`endif
);

  state_t      state;
  logic [31:0] rdata_q;
  logic        access;
  logic [31:0] w_read_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] busy_cnt;
`endif

  assign access    = MemtoRegM | MemWriteM;
  assign StallM    = ((state == IDLE) && access) || (state == BUSY);
  assign PCSrcM    = BranchM & ZeroM & ~StallM;
  assign PCBranchF = PCBranchM;

  // Only DONE forwards the captured read data, and never for a store.
  assign w_read_data = ((state == DONE) && !MemWriteM) ? rdata_q : BUBBLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      busy_cnt  <= '0;
      mem_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUOutM[ADDR_W-1:2], 2'b00};
            mem_wdata <= WriteDataM;
`ifdef MEM_TIMEOUT_EN
            busy_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          // An ack in the expiry cycle takes priority over the abort.
          else if (busy_cnt == CNT_LAST) begin
            rdata_q <= DEADBEEF;
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            state   <= DONE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (1'b1),
    .bubble       (StallM),
    .reg_write    (RegWriteM),
    .mem_to_reg   (MemtoRegM),
    .read_data    (w_read_data),
    .alu_out      (ALUOutM),
    .write_reg    (WriteRegM),
    .reg_write_w  (RegWriteW),
    .mem_to_reg_w (MemtoRegW),
    .read_data_w  (ReadDataW),
    .alu_out_w    (ALUOutW),
    .write_reg_w  (WriteRegW)
  );

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline MEM stage; sits directly downstream of the EX/MEM latch and consumes its *M signals.
- Resolves the branch (PCSrcM) and runs word loads/stores to data memory over a req/ack bus with variable latency.
- Stalls the upstream pipeline during a memory access and drives the registered MEM/WB outputs (*W).

Parameters:
- ADDR_W, 32, data-memory byte address width (upper bits of ALUOutM are used).
- TIMEOUT_CYCLES, 16, BUSY cycles before abort; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- RegWriteM  in  1  register write enable from the EX/MEM latch
- MemtoRegM  in  1  load instruction
- MemWriteM  in  1  store instruction
- BranchM  in  1  branch instruction
- ZeroM  in  1  ALU zero flag
- ALUOutM  in  32  ALU result / memory address
- WriteDataM  in  32  store data
- WriteRegM  in  5  destination register
- PCBranchM  in  32  branch target
- PCSrcM  out  1  take branch (to fetch)
- PCBranchF  out  32  branch target, equal to PCBranchM
- StallM  out  1  hold PC and all upstream latches this cycle
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  ADDR_W  word-aligned address, registered
- mem_wdata  out  32  store data, registered
- mem_ack  in  1  bus completion, one-cycle pulse
- mem_rdata  in  32  read data, valid when mem_ack = 1
- RegWriteW  out  1  registered MEM/WB output
- MemtoRegW  out  1  registered MEM/WB output
- ReadDataW  out  32  registered MEM/WB output
- ALUOutW  out  32  registered MEM/WB output
- WriteRegW  out  5  registered MEM/WB output

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset is asynchronous, active-low, on rst_n.
  - During reset, every registered output is 0 and the FSM is in IDLE.
  - Reset mid-access drops mem_req immediately; an ack arriving afterwards is ignored.
- access = MemtoRegM | MemWriteM.
- FSM IDLE:
  - If access = 0: StallM = 0; the W registers load the *M values; ReadDataW loads 0.
  - If access = 1: StallM = 1 and the W registers load a bubble (RegWriteW = 0, MemtoRegW = 0, other W fields 0).
  - On the IDLE -> BUSY transition: mem_req <= 1, mem_we <= MemWriteM, mem_addr <= {ALUOutM[ADDR_W-1:2], 2'b00}, mem_wdata <= WriteDataM.
- FSM BUSY:
  - StallM = 1; W registers load a bubble; mem_* held stable.
  - On mem_ack: rdata_q <= mem_rdata, mem_req <= 0, go to DONE.
- FSM DONE:
  - StallM = 0; W registers load the *M values; ReadDataW <= rdata_q (0 for a store); go to IDLE.
- Minimum latency (ack in the first BUSY cycle):
  - Two stall cycles.
  - W is updated at the end of the third cycle after the instruction enters M.
- The upstream pipeline holds the *M inputs constant while StallM = 1.
- PCSrcM = BranchM & ZeroM & ~StallM, combinational. Branches never access memory.
- Low address bits:
  - ALUOutM[1:0] is ignored: word access only, no alignment fault.
  - Address bits at and above ADDR_W are discarded.
- An ack in IDLE or DONE is ignored.
- Back-to-back accesses: DONE returns to IDLE, which sees access = 1 again and re-enters BUSY. There is exactly one non-stall cycle between them.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter in BUSY counts up to TIMEOUT_CYCLES.
  - On expiry: mem_req <= 0, rdata_q <= 32'hDEAD_BEEF, go to DONE.
  - An extra output port mem_err (1 bit) is set sticky until reset.
  - An ack arriving in the same cycle as expiry wins.
- Undefined: no counter and no mem_err port; BUSY waits for ack indefinitely.

Decomposition:
- Package mips_pkg holds:
  - the FSM state enum (IDLE, BUSY, DONE; 2 bits);
  - the constants BUBBLE = 0 and DEADBEEF;
  - the register-index width of 5.
- One natural sub-module, mem_wb_reg: the MEM/WB register with load and bubble controls.
- mem_stage contains the FSM, the bus registers and the branch logic.

Test Plan:
- ALU op, RegWriteM = 1, ALUOutM = 0x10, WriteRegM = 3, no access -> StallM = 0; the next cycle shows RegWriteW = 1, ALUOutW = 0x10, WriteRegW = 3; mem_req stays 0.
- Load, ALUOutM = 0x103, mem_ack in the first BUSY cycle with rdata 0xCAFE0001 -> mem_addr = 0x100, mem_we = 0, StallM high for 2 cycles, ReadDataW = 0xCAFE0001 and MemtoRegW = 1 in the following cycle.
- Store, WriteDataM = 0x55AA, ack delayed 5 cycles -> mem_we = 1, mem_wdata = 0x55AA, StallM high for 6 cycles, W holds a bubble throughout, RegWriteW = 0 afterwards.
- BranchM = 1, ZeroM = 1, PCBranchM = 0x400 -> PCSrcM = 1 and PCBranchF = 0x400 in the same cycle; with ZeroM = 0 -> PCSrcM = 0.
- Assert rst_n = 0 in BUSY, then send a late ack -> mem_req drops immediately and all outputs are 0; the stray ack causes no W update.
- With MEM_TIMEOUT_EN, issue a load and never ack -> after 16 BUSY cycles mem_err = 1 (sticky) and ReadDataW = 0xDEADBEEF.
